// File: rtl/pipeline_hazard_ctrl.sv
// Issue/stall scheduler for the 5-stage RV32I pipeline: register scoreboard, branch sequencing, perf counters.
// Optional macro HAZARD_WB_BYPASS_EN: treat a same-cycle WB as already written (register file write-through).
module pipeline_hazard_ctrl #(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_rd_we,
  input  logic                  id_is_branch,
  input  logic                  ex_br_valid,
  input  logic                  ex_br_taken,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  flush_id,
  output logic                  issue,
  output logic [1:0]            ctrl_state,
  output logic                  protocol_err,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      issue_cnt
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_BR_WAIT = 2'd1,
    ST_FLUSH   = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e                state_q, state_d;
  logic [NUM_REGS-1:0]   sb_q, sb_d;
  logic                  protocol_err_q, protocol_err_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]      issue_cnt_q, issue_cnt_d;

  logic                  wb_hit_rs1, wb_hit_rs2, wb_hit_rd;
  logic                  raw1, raw2, waw, hazard;
  logic                  issue_c;

`ifdef HAZARD_WB_BYPASS_EN
  assign wb_hit_rs1 = wb_valid & (wb_rd == id_rs1);
  assign wb_hit_rs2 = wb_valid & (wb_rd == id_rs2);
  assign wb_hit_rd  = wb_valid & (wb_rd == id_rd);
`else
  assign wb_hit_rs1 = 1'b0;
  assign wb_hit_rs2 = 1'b0;
  assign wb_hit_rd  = 1'b0;
`endif

  // x0 is never pending; a matching WB this cycle hides the hazard only in bypass builds.
  always_comb begin
    raw1   = id_use_rs1 & (id_rs1 != '0) & sb_q[id_rs1] & ~wb_hit_rs1;
    raw2   = id_use_rs2 & (id_rs2 != '0) & sb_q[id_rs2] & ~wb_hit_rs2;
    waw    = id_rd_we   & (id_rd  != '0) & sb_q[id_rd]  & ~wb_hit_rd;
    hazard = id_valid & (raw1 | raw2 | waw);
  end

  always_comb begin
    state_d  = state_q;
    issue_c  = 1'b0;
    stall_if = 1'b0;
    stall_id = 1'b0;
    flush_id = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        issue_c  = id_valid & ~hazard;
        stall_if = hazard;
        stall_id = hazard;
        if (issue_c && id_is_branch) begin
          state_d = ST_BR_WAIT;
        end
      end
      ST_BR_WAIT: begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        if (ex_br_valid) begin
          state_d = ex_br_taken ? ST_FLUSH : ST_RUN;
        end
      end
      ST_FLUSH: begin
        flush_id = 1'b1;
        state_d  = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Set after clear so a same-cycle WB and re-issue of one register leaves it pending.
  always_comb begin
    sb_d = sb_q;
    if (wb_valid) begin
      sb_d[wb_rd] = 1'b0;
    end
    if (issue_c && id_rd_we) begin
      sb_d[id_rd] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  always_comb begin
    protocol_err_d = protocol_err_q | (ex_br_valid & (state_q != ST_BR_WAIT));
    stall_cnt_d    = stall_cnt_q;
    issue_cnt_d    = issue_cnt_q;
    if (stall_id && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    if (issue_c && (issue_cnt_q != CNT_MAX)) begin
      issue_cnt_d = issue_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_RUN;
      sb_q           <= '0;
      protocol_err_q <= 1'b0;
      stall_cnt_q    <= '0;
      issue_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      sb_q           <= sb_d;
      protocol_err_q <= protocol_err_d;
      stall_cnt_q    <= stall_cnt_d;
      issue_cnt_q    <= issue_cnt_d;
    end
  end

  assign issue        = issue_c;
  assign ctrl_state   = state_q;
  assign protocol_err = protocol_err_q;
  assign stall_cnt    = stall_cnt_q;
  assign issue_cnt    = issue_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized and directed bench for pipeline_hazard_ctrl against a behavioural scoreboard model.
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

  localparam int CNT_MAX = 65535;

  typedef struct {
    bit       idValid;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit       use1;
    bit       use2;
    bit [4:0] rd;
    bit       rdWe;
    bit       isBr;
    bit       exBrValid;
    bit       exBrTaken;
    bit       wbValid;
    bit [4:0] wbRd;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        idValid = 1'b0, use1 = 1'b0, use2 = 1'b0, rdWe = 1'b0, isBr = 1'b0;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0, wbRd = '0;
  logic        exBrValid = 1'b0, exBrTaken = 1'b0, wbValid = 1'b0;
  logic        stallIf, stallId, flushId, issue, protocolErr;
  logic [1:0]  ctrlState;
  logic [15:0] stallCnt, issueCnt;

  int vecCount  = 0;
  int missCount = 0;

  // Reference model state: pending-write flags, branch phase, sticky error, counters.
  bit mPending [32];
  int mState;
  bit mErr;
  int mStallCnt, mIssueCnt;
  bit eIssue, eStallIf, eStallId, eFlush;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_valid(idValid), .id_rs1(rs1), .id_rs2(rs2),
    .id_use_rs1(use1), .id_use_rs2(use2),
    .id_rd(rd), .id_rd_we(rdWe), .id_is_branch(isBr),
    .ex_br_valid(exBrValid), .ex_br_taken(exBrTaken),
    .wb_valid(wbValid), .wb_rd(wbRd),
    .stall_if(stallIf), .stall_id(stallId), .flush_id(flushId), .issue(issue),
    .ctrl_state(ctrlState), .protocol_err(protocolErr),
    .stall_cnt(stallCnt), .issue_cnt(issueCnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic stim_t idleStim();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  task automatic modelReset();
    foreach (mPending[i]) mPending[i] = 1'b0;
    mState    = 0;
    mErr      = 1'b0;
    mStallCnt = 0;
    mIssueCnt = 0;
  endtask

  function automatic bit blocks(int idx, stim_t s);
    if (idx == 0) return 1'b0;
`ifdef HAZARD_WB_BYPASS_EN
    if (s.wbValid && int'(s.wbRd) == idx) return 1'b0;
`endif
    return mPending[idx];
  endfunction

  task automatic evalModel(input stim_t s);
    bit hz;
    hz = s.idValid && ((s.use1 && blocks(int'(s.rs1), s)) ||
                       (s.use2 && blocks(int'(s.rs2), s)) ||
                       (s.rdWe && blocks(int'(s.rd), s)));
    eIssue   = (mState == 0) && s.idValid && !hz;
    eStallId = (mState == 1) || ((mState == 0) && hz);
    eStallIf = eStallId;
    eFlush   = (mState == 2);
  endtask

  task automatic updateModel(input stim_t s);
    if (eStallId && mStallCnt < CNT_MAX) mStallCnt++;
    if (eIssue && mIssueCnt < CNT_MAX) mIssueCnt++;
    if (s.exBrValid && mState != 1) mErr = 1'b1;
    case (mState)
      0: if (eIssue && s.isBr) mState = 1;
      1: if (s.exBrValid) mState = s.exBrTaken ? 2 : 0;
      default: mState = 0;
    endcase
    if (s.wbValid && s.wbRd != 0) mPending[s.wbRd] = 1'b0;
    if (eIssue && s.rdWe && s.rd != 0) mPending[s.rd] = 1'b1;
  endtask

  task automatic checkAll();
    checkOutput("issue", 32'(issue), 32'(eIssue));
    checkOutput("stall_if", 32'(stallIf), 32'(eStallIf));
    checkOutput("stall_id", 32'(stallId), 32'(eStallId));
    checkOutput("flush_id", 32'(flushId), 32'(eFlush));
    checkOutput("ctrl_state", 32'(ctrlState), 32'(mState));
    checkOutput("protocol_err", 32'(protocolErr), 32'(mErr));
    checkOutput("stall_cnt", 32'(stallCnt), 32'(mStallCnt));
    checkOutput("issue_cnt", 32'(issueCnt), 32'(mIssueCnt));
  endtask

  task automatic applyStimulus(input stim_t s, input bit doCheck);
    @(negedge clk);
    idValid = s.idValid; rs1 = s.rs1; rs2 = s.rs2; use1 = s.use1; use2 = s.use2;
    rd = s.rd; rdWe = s.rdWe; isBr = s.isBr;
    exBrValid = s.exBrValid; exBrTaken = s.exBrTaken;
    wbValid = s.wbValid; wbRd = s.wbRd;
    #1;
    evalModel(s);
    if (doCheck) checkAll();
    @(posedge clk);
    updateModel(s);
  endtask

  // Asserts reset mid-cycle and checks that cleared state is visible before any clock edge.
  task automatic doReset();
    stim_t s;
    s = idleStim();
    @(negedge clk);
    idValid = 1'b0; use1 = 1'b0; use2 = 1'b0; rdWe = 1'b0; isBr = 1'b0;
    exBrValid = 1'b0; exBrTaken = 1'b0; wbValid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    evalModel(s);
    checkAll();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    stim_t s;
    modelReset();
    doReset();

    // RAW on x2: producer issues, consumer stalls until the WB of x2.
    s = idleStim(); s.idValid = 1; s.rdWe = 1; s.rd = 5'd2;
    applyStimulus(s, 1);
    s = idleStim(); s.idValid = 1; s.use1 = 1; s.rs1 = 5'd2;
    repeat (3) applyStimulus(s, 1);
    s.wbValid = 1; s.wbRd = 5'd2;
    applyStimulus(s, 1);
    s.wbValid = 0;
    applyStimulus(s, 1);
    applyStimulus(idleStim(), 1);

    // x0 is never tracked, then WAW on x3.
    s = idleStim(); s.idValid = 1; s.rdWe = 1; s.rd = 5'd0;
    applyStimulus(s, 1);
    s = idleStim(); s.idValid = 1; s.use1 = 1; s.rs1 = 5'd0; s.rdWe = 1; s.rd = 5'd3;
    applyStimulus(s, 1);
    s = idleStim(); s.idValid = 1; s.rdWe = 1; s.rd = 5'd3;
    repeat (2) applyStimulus(s, 1);
    s.wbValid = 1; s.wbRd = 5'd3;
    applyStimulus(s, 1);
    s.wbValid = 0;
    repeat (2) applyStimulus(s, 1);

    // Branch not taken, then branch taken.
    for (int t = 0; t < 2; t++) begin
      s = idleStim(); s.idValid = 1; s.isBr = 1;
      applyStimulus(s, 1);
      s = idleStim(); s.idValid = 1;
      repeat (2) applyStimulus(s, 1);
      s.exBrValid = 1; s.exBrTaken = bit'(t);
      applyStimulus(s, 1);
      s.exBrValid = 0; s.exBrTaken = 0;
      repeat (2) applyStimulus(s, 1);
    end

    // Reset while x5 is pending and a branch is outstanding.
    s = idleStim(); s.idValid = 1; s.rdWe = 1; s.rd = 5'd5;
    applyStimulus(s, 1);
    s = idleStim(); s.idValid = 1; s.isBr = 1;
    applyStimulus(s, 1);
    applyStimulus(idleStim(), 1);
    doReset();
    s = idleStim(); s.idValid = 1; s.use1 = 1; s.rs1 = 5'd5;
    applyStimulus(s, 1);

    // Randomized traffic on a small register window to provoke frequent hazards.
    for (int n = 0; n < 2000; n++) begin
      s = idleStim();
      s.idValid   = ($urandom_range(0, 3) != 0);
      s.rs1       = 5'($urandom_range(0, 7));
      s.rs2       = 5'($urandom_range(0, 7));
      s.use1      = 1'($urandom_range(0, 1));
      s.use2      = 1'($urandom_range(0, 1));
      s.rd        = 5'($urandom_range(0, 7));
      s.rdWe      = 1'($urandom_range(0, 1));
      s.isBr      = ($urandom_range(0, 7) == 0);
      s.wbValid   = ($urandom_range(0, 2) == 0);
      s.wbRd      = 5'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 31 : 7));
      s.exBrValid = (mState == 1) && ($urandom_range(0, 2) == 0);
      s.exBrTaken = 1'($urandom_range(0, 1));
      applyStimulus(s, 1);
    end

    // Branch resolution outside BR_WAIT is a sticky protocol error.
    doReset();
    s = idleStim(); s.exBrValid = 1; s.exBrTaken = 1;
    applyStimulus(s, 1);
    s = idleStim(); s.idValid = 1;
    repeat (3) applyStimulus(s, 1);
    doReset();

    // Saturation: hold a RAW stall long enough to overflow a 16-bit counter.
    s = idleStim(); s.idValid = 1; s.rdWe = 1; s.rd = 5'd2;
    applyStimulus(s, 1);
    s = idleStim(); s.idValid = 1; s.use1 = 1; s.rs1 = 5'd2;
    repeat (70000) applyStimulus(s, 0);
    checkOutput("stall_cnt_sat", 32'(stallCnt), 32'(CNT_MAX));
    repeat (2) applyStimulus(s, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
